// File: rtl/fractal_sync_mp_cnt_rf_if.sv
// rtl/fractal_sync_mp_cnt_rf_if.sv - multi-port access bundle for the sync counter register file
interface fractal_sync_mp_cnt_rf_if #(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned CNT_WIDTH = 4
);
  logic                 inc_i  [N_PORTS];
  logic                 clr_i  [N_PORTS];
  logic [IDX_WIDTH-1:0] idx_i  [N_PORTS];
  logic [CNT_WIDTH-1:0] tgt_i  [N_PORTS];
  logic [CNT_WIDTH-1:0] cnt_o  [N_PORTS];
  logic                 done_o [N_PORTS];
  logic                 err_o  [N_PORTS];

  modport master (
    output inc_i, clr_i, idx_i, tgt_i,
    input  cnt_o, done_o, err_o
  );

  modport slave (
    input  inc_i, clr_i, idx_i, tgt_i,
    output cnt_o, done_o, err_o
  );
endinterface

// File: rtl/fractal_sync_mp_cnt_rf.sv
// rtl/fractal_sync_mp_cnt_rf.sv - multi-port arrival counters with per-entry completion target
module fractal_sync_mp_cnt_rf #(
  parameter int unsigned N_REGS    = 4,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fractal_sync_mp_cnt_rf_if.slave  bus
);

  localparam int unsigned         KW        = $clog2(N_PORTS + 1);
  localparam int unsigned         SW        = CNT_WIDTH + KW;
  localparam logic [IDX_WIDTH:0]  NREGS_W   = (IDX_WIDTH + 1)'(N_REGS);
  localparam logic [SW-1:0]       CNT_MAX_W = SW'({CNT_WIDTH{1'b1}});

  if (2 ** IDX_WIDTH < N_REGS) begin : g_idx_check
    $error("IDX_WIDTH too small to address N_REGS entries");
  end

  logic [CNT_WIDTH-1:0] cnt_q  [N_REGS];
  logic [CNT_WIDTH-1:0] cnt_d  [N_REGS];
  logic                 cmpl   [N_REGS];
  logic                 sat    [N_REGS];
  logic                 done_q [N_PORTS];
  logic                 done_d [N_PORTS];
  logic                 err_q  [N_PORTS];
  logic                 err_d  [N_PORTS];
  logic                 in_rng [N_PORTS];
  logic                 cnt_en [N_PORTS];

  always_comb begin
    logic [KW-1:0]        k;
    logic [SW-1:0]        sum;
    logic [CNT_WIDTH-1:0] tgt;
    logic                 tgt_found;
    logic                 hit_clr;
    logic                 p_cmpl;
    logic                 p_sat;

    for (int p = 0; p < N_PORTS; p++) begin
      in_rng[p] = {1'b0, bus.idx_i[p]} < NREGS_W;
      cnt_en[p] = bus.inc_i[p] && !bus.clr_i[p] && in_rng[p] && (bus.tgt_i[p] != '0);
    end

    for (int e = 0; e < N_REGS; e++) begin
      k         = '0;
      tgt       = '0;
      tgt_found = 1'b0;
      hit_clr   = 1'b0;
      for (int p = 0; p < N_PORTS; p++) begin
        if (in_rng[p] && bus.idx_i[p] == IDX_WIDTH'(e)) begin
          if (bus.clr_i[p]) hit_clr = 1'b1;
          if (cnt_en[p]) begin
            k = k + KW'(1);
            // the lowest-numbered contributing port owns the target
            if (!tgt_found) begin
              tgt       = bus.tgt_i[p];
              tgt_found = 1'b1;
            end
          end
        end
      end
      sum     = SW'(cnt_q[e]) + SW'(k);
      cmpl[e] = !hit_clr && (k != '0) && (sum >= SW'(tgt));
      sat[e]  = !hit_clr && (k != '0) && !cmpl[e] && (sum > CNT_MAX_W);
      cnt_d[e] = cnt_q[e];
      if (hit_clr || cmpl[e]) cnt_d[e] = '0;
      else if (k != '0)       cnt_d[e] = sat[e] ? '1 : sum[CNT_WIDTH-1:0];
    end

    for (int p = 0; p < N_PORTS; p++) begin
      p_cmpl = 1'b0;
      p_sat  = 1'b0;
      for (int e = 0; e < N_REGS; e++) begin
        if (cnt_en[p] && bus.idx_i[p] == IDX_WIDTH'(e)) begin
          p_cmpl = cmpl[e];
          p_sat  = sat[e];
        end
      end
      err_d[p]  = ((bus.inc_i[p] || bus.clr_i[p]) && !in_rng[p])
               || (bus.inc_i[p] && bus.tgt_i[p] == '0)
               || p_sat;
      done_d[p] = p_cmpl && !err_d[p];
    end
  end

  // read port shows registered state only; same-cycle updates are not bypassed
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      bus.cnt_o[p]  = '0;
      for (int e = 0; e < N_REGS; e++) begin
        if (bus.idx_i[p] == IDX_WIDTH'(e)) bus.cnt_o[p] = cnt_q[e];
      end
      bus.done_o[p] = done_q[p];
      bus.err_o[p]  = err_q[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < N_REGS; e++) cnt_q[e] <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        done_q[p] <= 1'b0;
        err_q[p]  <= 1'b0;
      end
    end else begin
      for (int e = 0; e < N_REGS; e++) cnt_q[e] <= cnt_d[e];
      for (int p = 0; p < N_PORTS; p++) begin
        done_q[p] <= done_d[p];
        err_q[p]  <= err_d[p];
      end
    end
  end

endmodule

// File: tb/tb_fractal_sync_mp_cnt_rf.sv
// tb/tb_fractal_sync_mp_cnt_rf.sv - directed self-checking bench for fractal_sync_mp_cnt_rf
module tb_fractal_sync_mp_cnt_rf;

  logic clk_i;
  logic rst_ni;
  int   n_cmp;
  int   n_bad;

  fractal_sync_mp_cnt_rf_if #(.N_PORTS(2), .IDX_WIDTH(2), .CNT_WIDTH(4)) bus ();

  fractal_sync_mp_cnt_rf #(
    .N_REGS(3), .IDX_WIDTH(2), .N_PORTS(2), .CNT_WIDTH(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    for (int p = 0; p < 2; p++) begin
      bus.inc_i[p] = 1'b0;
      bus.clr_i[p] = 1'b0;
    end
  endtask

  task automatic drive(input logic i0, input logic c0, input logic [1:0] x0, input logic [3:0] t0,
                       input logic i1, input logic c1, input logic [1:0] x1, input logic [3:0] t1);
    bus.inc_i[0] = i0; bus.clr_i[0] = c0; bus.idx_i[0] = x0; bus.tgt_i[0] = t0;
    bus.inc_i[1] = i1; bus.clr_i[1] = c1; bus.idx_i[1] = x1; bus.tgt_i[1] = t1;
    @(posedge clk_i);
    #1;
    set_idle();
  endtask

  task automatic idle_cyc();
    @(posedge clk_i);
    #1;
  endtask

  // flags packed as {done1, done0, err1, err0}
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check_eq(tag, 32'({bus.done_o[1], bus.done_o[0], bus.err_o[1], bus.err_o[0]}), 32'(exp));
  endtask

  task automatic peek(input string tag, input logic [1:0] e, input logic [3:0] exp);
    bus.idx_i[0] = e;
    #1;
    check_eq(tag, 32'(bus.cnt_o[0]), 32'(exp));
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_ni = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus.inc_i[p] = 1'b0; bus.clr_i[p] = 1'b0;
      bus.idx_i[p] = '0;   bus.tgt_i[p] = '0;
    end
    #3;
    check_flags("rst_flags", 4'b0000);
    peek("rst_cnt0", 2'd0, 4'd0);
    peek("rst_cnt1", 2'd1, 4'd0);
    peek("rst_cnt2", 2'd2, 4'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;

    // three arrivals on entry 1, target 3
    drive(1, 0, 2'd1, 4'd3, 0, 0, 2'd0, 4'd0);
    check_flags("seq_a1_flags", 4'b0000);
    peek("seq_a1_cnt", 2'd1, 4'd1);
    drive(1, 0, 2'd1, 4'd3, 0, 0, 2'd0, 4'd0);
    check_flags("seq_a2_flags", 4'b0000);
    peek("seq_a2_cnt", 2'd1, 4'd2);
    drive(1, 0, 2'd1, 4'd3, 0, 0, 2'd0, 4'd0);
    check_flags("seq_a3_done", 4'b0100);
    peek("seq_a3_cnt", 2'd1, 4'd0);
    idle_cyc();
    check_flags("seq_pulse_once", 4'b0000);

    // two ports same entry: port0 target 2 wins over port1 target 5
    drive(1, 0, 2'd2, 4'd2, 1, 0, 2'd2, 4'd5);
    check_flags("dual_done", 4'b1100);
    peek("dual_cnt", 2'd2, 4'd0);

    // clear beats a simultaneous increment
    drive(1, 0, 2'd0, 4'd15, 1, 0, 2'd0, 4'd15);
    check_flags("clr_pre_flags", 4'b0000);
    peek("clr_pre_cnt2", 2'd0, 4'd2);
    drive(1, 0, 2'd0, 4'd15, 0, 0, 2'd0, 4'd0);
    peek("clr_pre_cnt3", 2'd0, 4'd3);
    drive(1, 0, 2'd0, 4'd4, 0, 1, 2'd0, 4'd0);
    check_flags("clr_flags", 4'b0000);
    peek("clr_cnt", 2'd0, 4'd0);

    // build entry 2 to 14, then zero target error, then clamp completion
    for (int i = 0; i < 7; i++) drive(1, 0, 2'd2, 4'd15, 1, 0, 2'd2, 4'd15);
    peek("fill_cnt", 2'd2, 4'd14);
    drive(1, 0, 2'd2, 4'd0, 0, 0, 2'd0, 4'd0);
    check_flags("tgt0_err", 4'b0001);
    peek("tgt0_cnt", 2'd2, 4'd14);
    drive(1, 0, 2'd2, 4'd15, 1, 0, 2'd2, 4'd15);
    check_flags("clamp_done", 4'b1100);
    peek("clamp_cnt", 2'd2, 4'd0);

    // port0 bad target errs while port1 completes the same entry
    drive(1, 0, 2'd2, 4'd0, 1, 0, 2'd2, 4'd1);
    check_flags("errwin_flags", 4'b1001);
    peek("errwin_cnt", 2'd2, 4'd0);

    // out-of-range index on each port
    drive(1, 0, 2'd0, 4'd15, 0, 0, 2'd0, 4'd0);
    peek("oor_pre_cnt0", 2'd0, 4'd1);
    drive(0, 0, 2'd0, 4'd0, 1, 0, 2'd3, 4'd5);
    check_flags("oor_inc_err", 4'b0010);
    peek("oor_cnt0", 2'd0, 4'd1);
    peek("oor_cnt1", 2'd1, 4'd0);
    peek("oor_cnt2", 2'd2, 4'd0);
    bus.idx_i[1] = 2'd3;
    #1;
    check_eq("oor_read", 32'(bus.cnt_o[1]), 32'd0);
    drive(0, 1, 2'd3, 4'd0, 0, 0, 2'd0, 4'd0);
    check_flags("oor_clr_err", 4'b0001);

    // completion pulse in flight is dropped by an asynchronous reset
    drive(1, 0, 2'd1, 4'd15, 0, 0, 2'd0, 4'd0);
    drive(1, 0, 2'd1, 4'd15, 0, 0, 2'd0, 4'd0);
    drive(1, 0, 2'd1, 4'd3, 0, 0, 2'd0, 4'd0);
    check_flags("inflight_done", 4'b0100);
    rst_ni = 1'b0;
    #1;
    check_flags("async_drop", 4'b0000);
    peek("async_cnt0", 2'd0, 4'd0);
    rst_ni = 1'b1;
    idle_cyc();
    check_flags("post_rst_a", 4'b0000);

    // reset before the completing edge: no pulse ever appears
    drive(1, 0, 2'd1, 4'd15, 0, 0, 2'd0, 4'd0);
    drive(1, 0, 2'd1, 4'd15, 0, 0, 2'd0, 4'd0);
    peek("pre_rst_cnt1", 2'd1, 4'd2);
    bus.inc_i[0] = 1'b1; bus.idx_i[0] = 2'd1; bus.tgt_i[0] = 4'd3;
    #1;
    rst_ni = 1'b0;
    #1;
    set_idle();
    peek("rst_b_cnt1", 2'd1, 4'd0);
    check_flags("rst_b_flags", 4'b0000);
    rst_ni = 1'b1;
    idle_cyc();
    check_flags("rst_b_after1", 4'b0000);
    idle_cyc();
    check_flags("rst_b_after2", 4'b0000);
    peek("rst_b_cnt1_end", 2'd1, 4'd0);

    // normal operation resumes
    drive(1, 0, 2'd0, 4'd2, 0, 0, 2'd0, 4'd0);
    check_flags("resume_flags", 4'b0000);
    peek("resume_cnt", 2'd0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fractal_sync_mp_cnt_rf.md
FRACTAL_SYNC_MP_CNT_RF -- requirements
Module: fractal_sync_mp_cnt_rf

Interface
REQ-001 SHALL have parameter N_REGS, default 4, number of counter entries.
REQ-002 SHALL have parameter IDX_WIDTH, default 2, entry index width; 2**IDX_WIDTH >= N_REGS is checked at elaboration.
REQ-003 SHALL have parameter N_PORTS, default 2, number of independent access ports.
REQ-004 SHALL have parameter CNT_WIDTH, default 4, counter and target width.
REQ-005 SHALL have one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-006 SHALL have port clk_i  input  1  clock, all state updates on the rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port inc_i[N_PORTS]  input  1  arrival strobe: increment the addressed entry.
REQ-009 SHALL have port clr_i[N_PORTS]  input  1  clear the addressed entry.
REQ-010 SHALL have port idx_i[N_PORTS]  input  IDX_WIDTH  entry index for inc/clr/read.
REQ-011 SHALL have port tgt_i[N_PORTS]  input  CNT_WIDTH  completion target, sampled with inc_i.
REQ-012 SHALL have port cnt_o[N_PORTS]  output  CNT_WIDTH  current value of entry idx_i.
REQ-013 SHALL have port done_o[N_PORTS]  output  1  registered completion pulse.
REQ-014 SHALL have port err_o[N_PORTS]  output  1  registered error pulse.

Function
REQ-015 SHALL treat a port as active when inc_i or clr_i is high and idx_i < N_REGS.
REQ-016 SHALL, per entry e per cycle, compute k(e) = number of ports with inc_i high, clr_i low and idx_i == e; sum = cnt[e] + k(e) at CNT_WIDTH+clog2(N_PORTS+1) bits, no truncation.
REQ-017 SHALL use as target of entry e the tgt_i of the lowest-numbered port incrementing e that cycle.
REQ-018 SHALL complete entry e when k(e) > 0 and sum >= target: cnt[e] <= 0 next edge.
REQ-019 SHALL otherwise, when k(e) > 0, load cnt[e] <= sum, saturating at 2**CNT_WIDTH-1.
REQ-020 SHALL give clr priority: any port with clr_i high on e forces cnt[e] <= 0, suppresses completion for e, ignores all increments to e that cycle.
REQ-021 SHALL pulse done_o[p] for exactly one cycle, on the cycle after the edge, for every port p that incremented an entry completing on that edge.
REQ-022 SHALL pulse err_o[p] one cycle after port p: idx_i >= N_REGS with inc_i or clr_i; inc_i with tgt_i == 0; or incrementing an entry that saturates without completing.
REQ-023 SHALL ignore out-of-range and tgt_i == 0 increments for counting (k excludes them).
REQ-024 SHALL drive cnt_o[p] combinationally as registered cnt[idx_i[p]], 0 when idx_i[p] >= N_REGS; no bypass of same-cycle updates.
REQ-025 SHALL make done_o and err_o mutually exclusive per port per cycle; err wins.
REQ-026 SHALL leave entries not addressed by any active port unchanged.
REQ-027 SHALL contain no combinational path from inputs to done_o or err_o.

Reset
REQ-028 SHALL, while rst_ni is low, immediately force all cnt entries, done_o and err_o to 0 regardless of clk_i.
REQ-029 SHALL drop any completion or error in flight when reset asserts mid-operation; no pulse appears after release.
REQ-030 SHALL resume normal operation on the first rising edge after rst_ni deasserts.

Verification
REQ-031 SHALL cover: port0 inc idx=1 tgt=3 on three separate cycles -> cnt_o 1,2, then done_o[0]=1 one cycle after third edge, cnt[1]=0.
REQ-032 SHALL cover: ports 0 and 1 inc idx=2 same cycle, tgt 2 and 5 from cnt=0 -> target 2 used, done_o[0]=done_o[1]=1 next cycle, cnt[2]=0.
REQ-033 SHALL cover: port0 inc idx=0 tgt=4 while port1 clr idx=0, cnt[0]=3 -> cnt[0]=0, no done_o, no err_o.
REQ-034 SHALL cover: CNT_WIDTH=4, cnt[3]=15, port0 inc idx=3 tgt=0xF is complete; tgt=0 -> err_o[0]=1, cnt unchanged; cnt=15 tgt=15 not met impossible, so tgt via clamp test: cnt=14 two ports inc tgt=15 -> done both, cnt 0.
REQ-035 SHALL cover: N_REGS=3, port1 inc idx=3 -> err_o[1]=1 next cycle, all entries unchanged, cnt_o[1]=0.
REQ-036 SHALL cover: cnt[1]=2, inc completing on edge, rst_ni pulsed low before next edge -> all cnt 0, done_o never asserts.
